guvm_instr_feeder: RTL and testbench
====================================

// Module: guvm_instr_feeder
// PURPOSE
// - Instruction-memory responder between the GUVM test interface and the RISCY core fetch port.
// - Bench pushes 32-bit instruction words into an internal FIFO.
// - Block answers core fetches with a grant/rvalid handshake, in order.
// - Replaces hand-driven instr_rdata_i/instr_gnt_i/instr_rvalid_i with a cycle-exact model.
// - Exposes the last fetch address and fetch/stall counters for the scoreboard.
// PARAMETERS
// - DEPTH      16  instruction FIFO entries; power of 2, >=2
// - CNT_W      32  width of fetch and stall counters
// - RESET_ADDR 0   reset value of last_addr_o (matches boot_addr_i)
// PORTS
// - clk_i          in   1     core clock
// - rst_i          in   1     synchronous, active-high reset
// - push_valid_i   in   1     bench offers an instruction
// - push_data_i    in   32    instruction word
// - push_ready_o   out  1     FIFO can accept (= !full)
// - flush_i        in   1     discard all queued (not yet granted) words
// - instr_req_i    in   1     from core instr_req_o
// - instr_addr_i   in   32    from core instr_addr_o
// - instr_gnt_o    out  1     to core instr_gnt_i
// - instr_rvalid_o out  1     to core instr_rvalid_i
// - instr_rdata_o  out  32    to core instr_rdata_i
// - level_o        out  $clog2(DEPTH)+1  FIFO occupancy
// - last_addr_o    out  32    address of most recent granted fetch
// - fetch_cnt_o    out  CNT_W granted fetches since reset
// - stall_cnt_o    out  CNT_W cycles with instr_req_i=1 and instr_gnt_o=0
// BEHAVIOUR
// - Reset (rst_i=1 at posedge): FIFO empty, state IDLE.
//   Outputs: gnt=0, rvalid=0, rdata=0, last_addr=RESET_ADDR, counters=0, push_ready=1.
// - Grant (combinational): gnt = instr_req_i & !empty & !flush_i & !rst_i.
//   A grant pops the FIFO head in the same cycle.
// - Response latency: rvalid=1 exactly one cycle after gnt; rdata = popped word (registered).
//   rvalid lasts one cycle. rdata holds its last value when rvalid=0.
// - FSM: IDLE -> RESP on gnt. RESP -> RESP on gnt (back-to-back, one grant per cycle).
//   RESP -> IDLE otherwise. At most one response outstanding.
// - Push: accepted when push_valid_i & push_ready_o. No bypass.
//   A word pushed into an empty FIFO is grantable the following cycle.
// - Full with simultaneous pop: push_ready_o is still 0 (ready depends only on full).
// - Empty with req: no gnt; stall_cnt increments each such cycle; core keeps req/addr stable.
// - Flush: clears FIFO and blocks gnt that cycle. A response already in RESP still completes.
//   Flush and push in the same cycle: flush wins, the word is dropped.
// - last_addr_o <= instr_addr_i on every gnt.
// - fetch_cnt_o and stall_cnt_o wrap modulo 2^CNT_W.
// - Reset mid-response: pending rvalid is cancelled, nothing is delivered.
// CONFIGURATION
// - Macro GUVM_FEEDER_NOP_FILL_EN.
// - Defined: on req with FIFO empty (and no flush), grant anyway.
//   Return NOP 32'h0000_0013 one cycle later; fetch_cnt increments; stall_cnt does not.
//   The core never stalls on an empty FIFO.
// - Undefined: empty FIFO withholds gnt as above; the NOP constant is unused.
// STRUCTURE
// - Package guvm_feeder_pkg: typedef enum logic {IDLE, RESP} feeder_state_e;
//   localparam logic [31:0] RV_NOP = 32'h0000_0013.
// - Sub-module guvm_sync_fifo #(WIDTH, DEPTH): push/pop/flush, full/empty/level.
// - Top level: FSM, response register, counters.
// TESTING
// - Reset, then push 3 words (A,B,C); hold req=1, addr 0/4/8.
//   -> gnt in 3 consecutive cycles; rvalid A,B,C one cycle later; fetch_cnt=3; last_addr=8.
// - req=1 with FIFO empty for 5 cycles, then push 0x00500093.
//   -> no gnt for 5 cycles, stall_cnt=5; gnt on cycle 7; rdata 0x00500093 on cycle 8.
// - Push 16 words (DEPTH=16).
//   -> push_ready=0, level=16; one pop -> ready=1 the next cycle, level=15.
// - Push 4 words, grant 1, assert flush_i with push_valid_i.
//   -> pending rvalid delivered; level=0; pushed word dropped; no gnt in the flush cycle.
// - rst_i asserted in the cycle after a gnt.
//   -> rvalid stays 0, counters=0, last_addr=0.
// - With GUVM_FEEDER_NOP_FILL_EN: req on empty FIFO.
//   -> gnt same cycle; rdata=0x00000013 next cycle; stall_cnt remains 0.

Source files
------------

// File: rtl/guvm_feeder_pkg.sv
// Shared types and constants for the GUVM instruction feeder.
package guvm_feeder_pkg;

  // Response FSM: IDLE = nothing outstanding, RESP = one response due this cycle
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } feeder_state_e;

  // RISC-V canonical NOP (addi x0, x0, 0), returned when filling an empty FIFO
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/guvm_sync_fifo.sv
// Synchronous FIFO with flush. DEPTH must be a power of two so the
// extra pointer MSB distinguishes full from empty.
module guvm_sync_fifo
  import guvm_feeder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign level_o = wr_ptr - rd_ptr;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign head_o  = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush discards everything and ignores a same-cycle push/pop
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i && !full_o)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_i && !empty_o)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !flush_i)
      mem[wr_ptr[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/guvm_instr_feeder.sv
// Instruction-memory responder for the RISCY fetch port: bench-fed FIFO,
// grant/rvalid handshake with one-cycle response latency, fetch/stall counters.
// Optional feature macro: GUVM_FEEDER_NOP_FILL_EN (grant on empty FIFO, return NOP).
module guvm_instr_feeder
  import guvm_feeder_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_valid_i,
  input  logic [31:0]               push_data_i,
  output logic                      push_ready_o,
  input  logic                      flush_i,
  input  logic                      instr_req_i,
  input  logic [31:0]               instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [31:0]               instr_rdata_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic [31:0]               last_addr_o,
  output logic [CNT_W-1:0]          fetch_cnt_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_head;
  logic          push_en;
  logic          pop_en;
  logic          gnt;
  logic [31:0]   rdata_nxt;
  feeder_state_e state_p1;
  logic [31:0]   rdata_p1;

`ifdef GUVM_FEEDER_NOP_FILL_EN
  // Never stall: an empty FIFO is answered with a NOP instead of a withheld grant
  assign gnt       = instr_req_i & ~flush_i & ~rst_i;
  assign pop_en    = gnt & ~fifo_empty;
  assign rdata_nxt = fifo_empty ? RV_NOP : fifo_head;
`else
  assign gnt       = instr_req_i & ~fifo_empty & ~flush_i & ~rst_i;
  assign pop_en    = gnt;
  assign rdata_nxt = fifo_head;
`endif

  // Ready depends only on full, so a full FIFO refuses a push even while popping
  assign push_ready_o   = ~fifo_full;
  assign push_en        = push_valid_i & ~fifo_full;
  assign instr_gnt_o    = gnt;
  // Reset in the response cycle cancels the pending delivery
  assign instr_rvalid_o = (state_p1 == RESP) & ~rst_i;
  assign instr_rdata_o  = rdata_p1;

  guvm_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_en),
    .push_data_i (push_data_i),
    .pop_i       (pop_en),
    .flush_i     (flush_i),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level_o)
  );

  // ---- stage p0 -> p1: grant registers the response for the next cycle ----

  // Response FSM: each grant produces exactly one rvalid cycle after it
  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_p1 <= IDLE;
    else
      state_p1 <= gnt ? RESP : IDLE;
  end

  // Response data and fetch address capture; both hold between grants
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_p1    <= '0;
      last_addr_o <= RESET_ADDR;
    end else if (gnt) begin
      rdata_p1    <= rdata_nxt;
      last_addr_o <= instr_addr_i;
    end
  end

  // Fetch and stall counters, wrapping modulo 2^CNT_W
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (gnt)
        fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
      if (instr_req_i && !gnt)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_guvm_instr_feeder.sv
// Bench for guvm_instr_feeder: directed scenarios plus random traffic, every
// cycle compared against a queue-based behavioural model of the fetch protocol.
module tb_guvm_instr_feeder;

  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
`ifdef GUVM_FEEDER_NOP_FILL_EN
  localparam bit NOP_FILL = 1'b1;
`else
  localparam bit NOP_FILL = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic                    push_valid;
  logic [31:0]             push_data;
  logic                    push_ready;
  logic                    flush;
  logic                    instr_req;
  logic [31:0]             instr_addr;
  logic                    instr_gnt;
  logic                    instr_rvalid;
  logic [31:0]             instr_rdata;
  logic [$clog2(DEPTH):0]  level;
  logic [31:0]             last_addr;
  logic [CNT_W-1:0]        fetch_cnt;
  logic [CNT_W-1:0]        stall_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] q[$];
  bit          m_rvalid;
  logic [31:0] m_rdata;
  logic [31:0] m_last;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  guvm_instr_feeder #(
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W),
    .RESET_ADDR (32'h0)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .push_valid_i   (push_valid),
    .push_data_i    (push_data),
    .push_ready_o   (push_ready),
    .flush_i        (flush),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .level_o        (level),
    .last_addr_o    (last_addr),
    .fetch_cnt_o    (fetch_cnt),
    .stall_cnt_o    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    m_last   = 32'h0;
    m_fetch  = 32'h0;
    m_stall  = 32'h0;
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, advance the model
  task automatic do_cycle(input bit req, input logic [31:0] addr, input bit pv,
                          input logic [31:0] pd, input bit fl, input bit r);
    bit          exp_gnt;
    bit          exp_ready;
    logic [31:0] word;
    instr_req  = req;
    instr_addr = addr;
    push_valid = pv;
    push_data  = pd;
    flush      = fl;
    rst        = r;
    exp_ready  = (q.size() < DEPTH);
    exp_gnt    = req && !fl && !r && (NOP_FILL || q.size() > 0);
    #2;
    chk("gnt",        32'(instr_gnt),    32'(exp_gnt));
    chk("push_ready", 32'(push_ready),   32'(exp_ready));
    chk("level",      32'(level),        32'(q.size()));
    chk("rvalid",     32'(instr_rvalid), 32'(m_rvalid && !r));
    chk("rdata",      instr_rdata,       m_rdata);
    chk("last_addr",  last_addr,         m_last);
    chk("fetch_cnt",  fetch_cnt,         m_fetch);
    chk("stall_cnt",  stall_cnt,         m_stall);
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (exp_gnt) begin
        if (q.size() > 0) word = q.pop_front();
        else              word = 32'h0000_0013;
        m_rdata = word;
        m_last  = addr;
        m_fetch = m_fetch + 32'd1;
      end
      m_rvalid = exp_gnt;
      if (req && !exp_gnt) m_stall = m_stall + 32'd1;
      if (fl)                   q.delete();
      else if (pv && exp_ready) q.push_back(pd);
    end
    instr_req  = 1'b0;
    push_valid = 1'b0;
    flush      = 1'b0;
    rst        = 1'b0;
    #1;
  endtask

  initial begin
    int s0;
    rst        = 1'b1;
    push_valid = 1'b0;
    push_data  = 32'h0;
    flush      = 1'b0;
    instr_req  = 1'b0;
    instr_addr = 32'h0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_gnt",    32'(instr_gnt),    32'd0);
    chk("rst_rvalid", 32'(instr_rvalid), 32'd0);
    chk("rst_rdata",  instr_rdata,       32'd0);
    chk("rst_last",   last_addr,         32'd0);
    chk("rst_fetch",  fetch_cnt,         32'd0);
    chk("rst_stall",  stall_cnt,         32'd0);
    chk("rst_ready",  32'(push_ready),   32'd1);
    chk("rst_level",  32'(level),        32'd0);

    // Three words, then back-to-back fetches at 0/4/8
    do_cycle(0, 32'h0, 1, 32'hAAAA_0001, 0, 0);
    do_cycle(0, 32'h0, 1, 32'hBBBB_0002, 0, 0);
    do_cycle(0, 32'h0, 1, 32'hCCCC_0003, 0, 0);
    do_cycle(1, 32'h0, 0, 32'h0, 0, 0);
    do_cycle(1, 32'h4, 0, 32'h0, 0, 0);
    do_cycle(1, 32'h8, 0, 32'h0, 0, 0);
    chk("abc_rvalid_c", 32'(instr_rvalid), 32'd1);
    chk("abc_rdata_c",  instr_rdata,       32'hCCCC_0003);
    chk("abc_fetch",    fetch_cnt,         32'd3);
    chk("abc_last",     last_addr,         32'd8);
    do_cycle(0, 32'h0, 0, 32'h0, 0, 0);

    // Starved fetch: 5 stall cycles, then a push, grant, response
    if (!NOP_FILL) begin
      for (int i = 0; i < 5; i++) do_cycle(1, 32'h10, 0, 32'h0, 0, 0);
      chk("starve_stall", stall_cnt, 32'd5);
    end
    do_cycle(1, 32'h10, 1, 32'h0050_0093, 0, 0);
    do_cycle(1, 32'h10, 0, 32'h0, 0, 0);
    chk("starve_rvalid", 32'(instr_rvalid), 32'd1);
    chk("starve_rdata",  instr_rdata,       32'h0050_0093);
    do_cycle(0, 32'h0, 0, 32'h0, 0, 0);

    // Fill to DEPTH, then pop once while offering a push
    for (int i = 0; i < DEPTH; i++) do_cycle(0, 32'h0, 1, 32'h1000 + 32'(i), 0, 0);
    chk("full_ready", 32'(push_ready), 32'd0);
    chk("full_level", 32'(level),      32'd16);
    do_cycle(1, 32'h20, 1, 32'hDEAD_BEEF, 0, 0);
    chk("pop_ready", 32'(push_ready), 32'd1);
    chk("pop_level", 32'(level),      32'd15);
    for (int i = 0; i < DEPTH; i++) do_cycle(1, 32'h24 + 32'(4*i), 0, 32'h0, 0, 0);

    // Flush with a response outstanding and a simultaneous push
    for (int i = 0; i < 4; i++) do_cycle(0, 32'h0, 1, 32'h2000 + 32'(i), 0, 0);
    do_cycle(1, 32'h40, 0, 32'h0, 0, 0);
    do_cycle(1, 32'h44, 1, 32'h7777_7777, 1, 0);
    chk("flush_level", 32'(level), 32'd0);
    do_cycle(0, 32'h0, 0, 32'h0, 0, 0);

    // Reset in the cycle after a grant
    do_cycle(0, 32'h0, 1, 32'h3333_3333, 0, 0);
    do_cycle(1, 32'h80, 0, 32'h0, 0, 0);
    do_cycle(0, 32'h0, 0, 32'h0, 0, 1);
    chk("mid_rst_rvalid", 32'(instr_rvalid), 32'd0);
    chk("mid_rst_fetch",  fetch_cnt,         32'd0);
    chk("mid_rst_stall",  stall_cnt,         32'd0);
    chk("mid_rst_last",   last_addr,         32'd0);
    do_cycle(0, 32'h0, 0, 32'h0, 0, 0);

`ifdef GUVM_FEEDER_NOP_FILL_EN
    // Empty FIFO still grants and returns a NOP
    do_cycle(1, 32'h100, 0, 32'h0, 0, 0);
    chk("nop_rvalid", 32'(instr_rvalid), 32'd1);
    chk("nop_rdata",  instr_rdata,       32'h0000_0013);
    chk("nop_stall",  stall_cnt,         32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      do_cycle($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 1) != 0, $urandom,
               $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
